// File: rtl/wb_scan_counter.sv
// Wishbone-controlled prescaled up/down counter with compare-match interrupt
// and a time-multiplexed hex 7-segment display driver.
module wb_scan_counter #(
  parameter int BITS   = 16,
  parameter int DIGITS = BITS / 4,
  parameter int PRE_W  = 16,
  parameter int SCAN_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              ext_gate_i,
  output logic [BITS-1:0]   count_o,
  output logic [6:0]        seg_o,
  output logic [DIGITS-1:0] dig_o,
  output logic              irq_o
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [BITS-1:0]   count_q, count_d, cmp_q, cmp_d, tick_val;
  logic [PRE_W-1:0]  pre_q, pre_d, pre_cnt_q, pre_cnt_d;
  logic              en_q, en_d, down_q, down_d, reload_q, reload_d;
  logic              pol_q, pol_d, irq_en_q, irq_en_d, match_q, match_d;
  logic              ack_q;
  logic [31:0]       dat_q, dat_d, rd_word, wmask;
  logic [SCAN_W-1:0] scan_cnt_q;
  logic [IDX_W-1:0]  scan_idx_q;
  logic              valid, access, wr, tick, hit, clr;
  logic [3:0]        nibble;
  logic [6:0]        glyph;
  logic [DIGITS-1:0] onehot;
  logic              unused_bits;

  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i};

  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign wmask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
  end

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h3F;  4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;  4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;  4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;  4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;  4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;  4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;  4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;  default: hex_glyph = 7'h71;
    endcase
  endfunction

  always_comb begin
    valid  = wbs_cyc_i && wbs_stb_i;
    access = valid && !ack_q;
    wr     = access && wbs_we_i;
    tick   = en_q && ext_gate_i && (pre_cnt_q == '0);
    hit    = tick && (count_q == cmp_q);

    tick_val = count_q;
    if (tick) begin
      if (!down_q)
        tick_val = (hit && reload_q) ? '0 : count_q + BITS'(1);
      else if (count_q == '0)
        tick_val = reload_q ? cmp_q : '1;
      else
        tick_val = count_q - BITS'(1);
    end

    pre_cnt_d = pre_cnt_q;
    if (en_q && ext_gate_i)
      pre_cnt_d = (pre_cnt_q == '0) ? pre_q : pre_cnt_q - PRE_W'(1);

    // A COUNT write only replaces the selected bytes; the rest keep the tick result.
    count_d  = tick_val;
    cmp_d    = cmp_q;
    pre_d    = pre_q;
    en_d     = en_q;
    down_d   = down_q;
    reload_d = reload_q;
    pol_d    = pol_q;
    irq_en_d = irq_en_q;
    clr      = 1'b0;
    if (wr) begin
      case (wbs_adr_i[3:2])
        2'd0: count_d = (tick_val & ~wmask[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & wmask[BITS-1:0]);
        2'd1: begin
          if (wbs_sel_i[0]) begin
            en_d     = wbs_dat_i[0];
            down_d   = wbs_dat_i[1];
            reload_d = wbs_dat_i[2];
            pol_d    = wbs_dat_i[3];
            irq_en_d = wbs_dat_i[4];
          end
          clr = wbs_sel_i[1] && wbs_dat_i[8];
        end
        2'd2: cmp_d = (cmp_q & ~wmask[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & wmask[BITS-1:0]);
        default: pre_d = (pre_q & ~wmask[PRE_W-1:0]) | (wbs_dat_i[PRE_W-1:0] & wmask[PRE_W-1:0]);
      endcase
    end
    // A match in the same cycle as a clear request wins.
    match_d = (match_q && !clr) || hit;

    rd_word = '0;
    case (wbs_adr_i[3:2])
      2'd0: rd_word[BITS-1:0] = count_q;
      2'd1: rd_word[8:0] = {match_q, 3'b000, irq_en_q, pol_q, reload_q, down_q, en_q};
      2'd2: rd_word[BITS-1:0] = cmp_q;
      default: rd_word[PRE_W-1:0] = pre_q;
    endcase
    dat_d = (access && !wbs_we_i) ? rd_word : dat_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      cmp_q      <= '1;
      pre_q      <= '0;
      pre_cnt_q  <= '0;
      en_q       <= 1'b0;
      down_q     <= 1'b0;
      reload_q   <= 1'b0;
      pol_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      match_q    <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else begin
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      pre_q      <= pre_d;
      pre_cnt_q  <= pre_cnt_d;
      en_q       <= en_d;
      down_q     <= down_d;
      reload_q   <= reload_d;
      pol_q      <= pol_d;
      irq_en_q   <= irq_en_d;
      match_q    <= match_d;
      ack_q      <= access;
      dat_q      <= dat_d;
      scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
      if (&scan_cnt_q)
        scan_idx_q <= (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    nibble = 4'(count_q >> {scan_idx_q, 2'b00});
    glyph  = hex_glyph(nibble);
    onehot = DIGITS'(1) << scan_idx_q;
  end

  assign seg_o     = pol_q ? glyph : ~glyph;
  assign dig_o     = pol_q ? onehot : ~onehot;
  assign count_o   = count_q;
  assign irq_o     = match_q && irq_en_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_scan_counter.sv
// Self-checking bench for wb_scan_counter: a 16-bit instance checked against a
// cycle-level reference model, plus a 32-bit fast-scan instance for the display.
module tb_wb_scan_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, gate = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat = '0;

  logic        ack16, irq16, ack32, irq32;
  logic [31:0] dat16, dat32;
  logic [15:0] count16;
  logic [31:0] count32;
  logic [6:0]  seg16, seg32;
  logic [3:0]  dig16;
  logic [7:0]  dig32;

  wb_scan_counter dut16 (
    .clk(clk), .reset(reset), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack16),
    .wbs_dat_o(dat16), .ext_gate_i(gate), .count_o(count16), .seg_o(seg16),
    .dig_o(dig16), .irq_o(irq16)
  );

  wb_scan_counter #(.BITS(32), .SCAN_W(2)) dut32 (
    .clk(clk), .reset(reset), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack32),
    .wbs_dat_o(dat32), .ext_gate_i(gate), .count_o(count32), .seg_o(seg32),
    .dig_o(dig32), .irq_o(irq32)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model of the 16-bit instance
  int unsigned m_count, m_cmp, m_pre, m_pre_cnt, m_rdata;
  logic m_en, m_down, m_reload, m_pol, m_irqen, m_match, m_ack;
  int unsigned m_cyc;

  function automatic logic [6:0] glyph_of(input int unsigned n);
    case (n & 15)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Advance one clock: model the edge from the current inputs, then settle at negedge.
  task automatic step();
    int unsigned c, nc, ncmp, npre, npc, nrd, mask;
    logic acc, tick, hit, clr, nen, ndown, nrel, npol, nirq;
    acc  = cyc && stb && !m_ack;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    tick = m_en && gate && (m_pre_cnt == 0);
    hit  = tick && (m_count == m_cmp);
    c = m_count; nc = c;
    if (tick) begin
      if (!m_down) nc = (hit && m_reload) ? 0 : (c + 1) % 65536;
      else if (c == 0) nc = m_reload ? m_cmp : 65535;
      else nc = c - 1;
    end
    npc = m_pre_cnt;
    if (m_en && gate) npc = (m_pre_cnt == 0) ? m_pre : m_pre_cnt - 1;
    ncmp = m_cmp; npre = m_pre; nrd = m_rdata; clr = 1'b0;
    nen = m_en; ndown = m_down; nrel = m_reload; npol = m_pol; nirq = m_irqen;
    if (acc && !we) begin
      case (adr[3:2])
        2'd0: nrd = m_count;
        2'd1: nrd = (int'(m_match) << 8) + (int'(m_irqen) << 4) + (int'(m_pol) << 3)
                    + (int'(m_reload) << 2) + (int'(m_down) << 1) + int'(m_en);
        2'd2: nrd = m_cmp;
        default: nrd = m_pre;
      endcase
    end
    if (acc && we) begin
      case (adr[3:2])
        2'd0: nc = ((nc & ~mask) | (dat & mask)) & 32'hFFFF;
        2'd1: begin
          if (sel[0]) begin
            nen = dat[0]; ndown = dat[1]; nrel = dat[2]; npol = dat[3]; nirq = dat[4];
          end
          clr = sel[1] && dat[8];
        end
        2'd2: ncmp = ((m_cmp & ~mask) | (dat & mask)) & 32'hFFFF;
        default: npre = ((m_pre & ~mask) | (dat & mask)) & 32'hFFFF;
      endcase
    end
    @(posedge clk);
    if (reset) begin
      m_count = 0; m_cmp = 32'hFFFF; m_pre = 0; m_pre_cnt = 0; m_rdata = 0;
      m_en = 0; m_down = 0; m_reload = 0; m_pol = 0; m_irqen = 0; m_match = 0;
      m_ack = 0; m_cyc = 0;
    end else begin
      m_match = (m_match && !clr) || hit;
      m_count = nc; m_cmp = ncmp; m_pre = npre; m_pre_cnt = npc; m_rdata = nrd;
      m_en = nen; m_down = ndown; m_reload = nrel; m_pol = npol; m_irqen = nirq;
      m_ack = acc; m_cyc++;
    end
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
    cyc = 1; stb = 1; we = 1; adr = {28'h0, idx, 2'b00}; dat = d; sel = s;
    step();
    cyc = 0; stb = 0; we = 0;
    step();
    $display("wb write reg=%0d data=%h sel=%b", idx, d, s);
  endtask

  task automatic wb_read(input logic [1:0] idx, output logic [31:0] rd);
    cyc = 1; stb = 1; we = 0; adr = {28'h0, idx, 2'b00}; sel = 4'hF;
    step();
    rd = dat16;
    cyc = 0; stb = 0;
    step();
    $display("wb read  reg=%0d data=%h", idx, rd);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1;
    repeat (3) step();
    reset = 0;
    checks++; if (count16 !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", count16); end
    checks++; if (ack16 !== 1'b0 || irq16 !== 1'b0 || dat16 !== 32'h0) begin failures++;
      $display("FAIL reset_bus ack=%b irq=%b dat=%h exp 0/0/0", ack16, irq16, dat16); end
    checks++; if (dig16 !== 4'b1110 || seg16 !== 7'h40) begin failures++;
      $display("FAIL reset_disp16 dig=%b seg=%h exp dig=1110 seg=40", dig16, seg16); end
    checks++; if (dig32 !== 8'hFE || seg32 !== 7'h40) begin failures++;
      $display("FAIL reset_disp32 dig=%b seg=%h exp dig=fe seg=40", dig32, seg32); end
    wb_read(2'd2, rd);
    checks++; if (rd !== 32'h0000FFFF) begin failures++; $display("FAIL reset_cmp got=%h exp=0000ffff", rd); end
    checks++; if (dat32 !== 32'hFFFFFFFF) begin failures++; $display("FAIL reset_cmp32 got=%h exp=ffffffff", dat32); end
    wb_read(2'd0, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_count_rd got=%h exp=0", rd); end
    wb_read(2'd1, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_ctrl_rd got=%h exp=0", rd); end
  endtask

  task automatic test_prescale();
    logic [15:0] prev, held;
    int last, changes;
    gate = 1;
    wb_write(2'd3, 32'd3, 4'hF);
    wb_write(2'd1, 32'h1, 4'hF);
    prev = count16; last = -1; changes = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++; if (count16 !== 16'(m_count)) begin failures++;
        $display("FAIL prescale_count i=%0d got=%h exp=%h", i, count16, 16'(m_count)); end
      if (count16 != prev) begin
        changes++;
        if (last >= 0) begin
          checks++; if (i - last != 4) begin failures++;
            $display("FAIL prescale_period i=%0d got=%0d exp=4", i, i - last); end
        end
        last = i; prev = count16;
      end
    end
    checks++; if (changes != 10) begin failures++; $display("FAIL prescale_ticks got=%0d exp=10", changes); end
    gate = 0; held = count16;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (count16 !== held) begin failures++;
        $display("FAIL gate_hold i=%0d got=%h exp=%h", i, count16, held); end
    end
    gate = 1;
  endtask

  task automatic test_reload_irq();
    logic [15:0] prev;
    logic wrapped;
    wb_write(2'd1, 32'h0, 4'hF);
    wb_write(2'd0, 32'h0, 4'hF);
    wb_write(2'd2, 32'd5, 4'hF);
    wb_write(2'd3, 32'd0, 4'hF);
    wb_write(2'd1, 32'h1D, 4'hF);
    prev = count16; wrapped = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++; if (count16 !== 16'(m_count) || irq16 !== (m_match && m_irqen)) begin failures++;
        $display("FAIL reload_model i=%0d count=%h irq=%b exp count=%h irq=%b", i, count16, irq16,
                 16'(m_count), m_match && m_irqen); end
      checks++; if (count16 > 16'd5) begin failures++; $display("FAIL reload_range i=%0d got=%h max=5", i, count16); end
      if (prev == 16'd5 && count16 != prev) begin
        wrapped = 1;
        checks++; if (count16 !== 16'd0 || irq16 !== 1'b1) begin failures++;
          $display("FAIL reload_wrap i=%0d count=%h irq=%b exp count=0 irq=1", i, count16, irq16); end
      end else if (!wrapped) begin
        checks++; if (irq16 !== 1'b0) begin failures++; $display("FAIL irq_early i=%0d got=%b exp=0", i, irq16); end
      end
      prev = count16;
    end
    wb_write(2'd1, 32'h1C, 4'hF);
    checks++; if (irq16 !== 1'b1) begin failures++; $display("FAIL irq_sticky got=%b exp=1", irq16); end
    wb_write(2'd1, 32'h118, 4'hF);
    checks++; if (irq16 !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq16); end
  endtask

  task automatic test_set_beats_clear();
    gate = 0;
    wb_write(2'd1, 32'h1D, 4'hF);
    wb_write(2'd0, 32'd5, 4'hF);
    wb_write(2'd1, 32'h11D, 4'hF);
    checks++; if (irq16 !== 1'b0) begin failures++; $display("FAIL sbc_pre got=%b exp=0", irq16); end
    cyc = 1; stb = 1; we = 1; adr = 32'h4; dat = 32'h11D; sel = 4'hF; gate = 1;
    step();
    gate = 0; cyc = 0; stb = 0; we = 0;
    checks++; if (irq16 !== 1'b1 || count16 !== 16'd0) begin failures++;
      $display("FAIL set_beats_clear irq=%b count=%h exp irq=1 count=0", irq16, count16); end
    step();
    wb_write(2'd1, 32'h100, 4'hF);
  endtask

  task automatic test_down();
    gate = 1;
    wb_write(2'd0, 32'd1, 4'hF);
    cyc = 1; stb = 1; we = 1; adr = 32'h4; dat = 32'h3; sel = 4'hF;
    step();
    cyc = 0; stb = 0; we = 0;
    checks++; if (count16 !== 16'd1) begin failures++; $display("FAIL down_start got=%h exp=1", count16); end
    step();
    checks++; if (count16 !== 16'd0) begin failures++; $display("FAIL down_t1 got=%h exp=0", count16); end
    step();
    checks++; if (count16 !== 16'hFFFF) begin failures++; $display("FAIL down_wrap got=%h exp=ffff", count16); end
    step();
    checks++; if (count16 !== 16'hFFFE || count16 !== 16'(m_count)) begin failures++;
      $display("FAIL down_t3 got=%h exp=fffe", count16); end
    wb_write(2'd1, 32'h0, 4'hF);
    wb_write(2'd0, 32'h0, 4'hF);
    wb_write(2'd2, 32'd7, 4'hF);
    cyc = 1; stb = 1; we = 1; adr = 32'h4; dat = 32'h7; sel = 4'hF;
    step();
    cyc = 0; stb = 0; we = 0;
    step();
    checks++; if (count16 !== 16'd7) begin failures++; $display("FAIL down_reload got=%h exp=7", count16); end
    step();
    checks++; if (count16 !== 16'd6) begin failures++; $display("FAIL down_after_reload got=%h exp=6", count16); end
    wb_write(2'd1, 32'h0, 4'hF);
  endtask

  task automatic test_collision();
    gate = 0;
    wb_write(2'd1, 32'h1, 4'hF);
    wb_write(2'd0, 32'h12FF, 4'hF);
    cyc = 1; stb = 1; we = 1; adr = 32'h0; dat = 32'hAB; sel = 4'b0001; gate = 1;
    step();
    gate = 0; cyc = 0; stb = 0; we = 0;
    checks++; if (count16 !== 16'h13AB) begin failures++; $display("FAIL collide16 got=%h exp=13ab", count16); end
    checks++; if (count32 !== 32'h13AB) begin failures++; $display("FAIL collide32 got=%h exp=000013ab", count32); end
    step();
    checks++; if (count16 !== 16'h13AB) begin failures++; $display("FAIL collide_hold got=%h exp=13ab", count16); end
    wb_write(2'd1, 32'h0, 4'hF);
  endtask

  task automatic test_back_to_back();
    cyc = 1; stb = 1; we = 0; adr = 32'h8; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (ack16 !== ((i % 2) == 0) || ack16 !== m_ack) begin failures++;
        $display("FAIL b2b_ack i=%0d got=%b exp=%b", i, ack16, (i % 2) == 0); end
      checks++; if (dat16 !== 32'd7) begin failures++; $display("FAIL b2b_data i=%0d got=%h exp=7", i, dat16); end
    end
    cyc = 0; stb = 0;
    step();
    $display("wb held read reg=2 x6");
  endtask

  task automatic test_reset_mid();
    cyc = 1; stb = 1; we = 0; adr = 32'h0; reset = 1;
    step();
    checks++; if (ack16 !== 1'b0) begin failures++; $display("FAIL rstmid_ack0 got=%b exp=0", ack16); end
    step();
    reset = 0;
    step();
    checks++; if (ack16 !== 1'b1 || count16 !== 16'h0) begin failures++;
      $display("FAIL rstmid_resume ack=%b count=%h exp ack=1 count=0", ack16, count16); end
    cyc = 0; stb = 0;
    step();
  endtask

  task automatic test_scan();
    int unsigned i32, i16;
    gate = 0;
    wb_write(2'd1, 32'h08, 4'hF);
    wb_write(2'd0, 32'h89ABCDEF, 4'hF);
    checks++; if (count32 !== 32'h89ABCDEF) begin failures++; $display("FAIL scan_count32 got=%h exp=89abcdef", count32); end
    for (int i = 0; i < 40; i++) begin
      step();
      i32 = (m_cyc / 4) % 8;
      i16 = (m_cyc / 1024) % 4;
      checks++; if (dig32 !== (8'h01 << i32) || seg32 !== glyph_of(32'h89ABCDEF >> (4 * i32))) begin failures++;
        $display("FAIL scan32 i=%0d dig=%b seg=%h exp dig=%b seg=%h", i, dig32, seg32,
                 8'h01 << i32, glyph_of(32'h89ABCDEF >> (4 * i32))); end
      checks++; if (dig16 !== (4'h1 << i16) || seg16 !== glyph_of(32'hCDEF >> (4 * i16))) begin failures++;
        $display("FAIL scan16 i=%0d dig=%b seg=%h exp dig=%b seg=%h", i, dig16, seg16,
                 4'h1 << i16, glyph_of(32'hCDEF >> (4 * i16))); end
    end
    wb_write(2'd1, 32'h0, 4'hF);
    i32 = (m_cyc / 4) % 8;
    checks++; if (dig32 !== ~(8'h01 << i32) || seg32 !== ~glyph_of(32'h89ABCDEF >> (4 * i32))) begin failures++;
      $display("FAIL scan_pol0 dig=%b seg=%h exp dig=%b seg=%h", dig32, seg32,
               ~(8'h01 << i32), ~glyph_of(32'h89ABCDEF >> (4 * i32))); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [1:0] idx;
    for (int i = 0; i < 400; i++) begin
      if (cyc) begin
        cyc = 0; stb = 0; we = 0;
      end else if ($urandom_range(3) == 0) begin
        idx = 2'($urandom_range(3));
        d = $urandom;
        if (idx == 2'd1 && $urandom_range(3) != 0) d[0] = 1'b1;
        if (idx == 2'd2) d = d & 32'h3F;
        if (idx == 2'd3) d = d & 32'h7;
        cyc = 1; stb = 1; we = 1'($urandom_range(1)); adr = {28'h0, idx, 2'b00};
        dat = d; sel = 4'($urandom_range(15));
        $display("wb rand %s reg=%0d data=%h sel=%b", we ? "write" : "read ", idx, d, sel);
      end
      gate = ($urandom_range(3) != 0);
      step();
      checks++; if (count16 !== 16'(m_count) || irq16 !== (m_match && m_irqen)) begin failures++;
        $display("FAIL rand_state i=%0d count=%h irq=%b exp count=%h irq=%b", i, count16, irq16,
                 16'(m_count), m_match && m_irqen); end
      checks++; if (ack16 !== m_ack || dat16 !== m_rdata) begin failures++;
        $display("FAIL rand_bus i=%0d ack=%b dat=%h exp ack=%b dat=%h", i, ack16, dat16, m_ack, m_rdata); end
    end
    cyc = 0; stb = 0; we = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_reload_irq();
    test_set_beats_clear();
    test_down();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_scan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
